mdr_unit: RTL and testbench
===========================

// Module: mdr_unit
// PURPOSE
//  Parametrised memory data register with an integrated memory-port sequencer.
//  Loads from the CPU bus, or performs a handshaked memory read or write of byte, half, word or dword size.
//  Reads are lane-extracted and sign- or zero-extended into the register.
//  Sits between the datapath bus (BusMuxOut) and the memory interface.
//  Replaces the plain MDR register and mux pair.
// PARAMETERS
//  DATA_W   32  register/memory data width; legal values 32 or 64
//  TIMEOUT  15  cycles to wait for mem_ack before aborting (1..255)
//  OFF_W    derived: log2(DATA_W/8), width of byte_off (localparam)
// PORTS
//  clock      in   1          rising-edge clock
//  reset      in   1          asynchronous, active-high reset
//  bus_in     in   DATA_W     datapath bus value (BusMuxOut)
//  mdr_in     in   1          load bus_in into mdr_q (IDLE only)
//  mem_rd     in   1          start memory read (IDLE only)
//  mem_wr     in   1          start memory write of mdr_q (IDLE only)
//  size       in   2          00 byte, 01 half, 10 word, 11 dword (DATA_W=64 only)
//  sign_ext   in   1          reads: 1 sign-extend, 0 zero-extend
//  byte_off   in   OFF_W      address low bits selecting the lane
//  mem_ack    in   1          memory completes the current request
//  mem_rdata  in   DATA_W     memory read data, valid with mem_ack
//  mem_req    out  1          registered request, held until ack or timeout
//  mem_we     out  1          1 for write request; valid while mem_req
//  mem_be     out  DATA_W/8   byte enables; valid while mem_req
//  mem_wdata  out  DATA_W     write data, lane-replicated; valid while mem_req
//  mdr_q      out  DATA_W     register contents
//  busy       out  1          state != IDLE
//  done       out  1          one-cycle pulse after a transfer ends (ack or abort)
//  err        out  1          sticky; set on misalignment, illegal size or timeout
// BEHAVIOUR
//  Reset (async, any time, including mid-transfer):
//   - state=IDLE; mdr_q, mem_req, mem_we, mem_be, mem_wdata, done, err, timer all 0.
//  States: IDLE, RD_WAIT, WR_WAIT.
//  IDLE priority: mem_rd > mem_wr > mdr_in. Lower-priority inputs asserted in the same cycle are ignored.
//  Any start in IDLE clears err at that edge, then checks the request:
//   - Misaligned: half with byte_off[0]!=0, word with byte_off[1:0]!=0, dword with byte_off!=0.
//   - Illegal: size=11 when DATA_W=32.
//   - On misaligned or illegal: err<=1, done pulses next cycle, no request, mdr_q unchanged.
//  mdr_in in IDLE: mdr_q<=bus_in at the edge. No done pulse, err unchanged.
//  Read: IDLE->RD_WAIT; mem_req=1 and mem_we=0 from the next cycle; mem_be = enabled lanes.
//  Write: IDLE->WR_WAIT; mem_we=1.
//   - mem_wdata = low size bytes of mdr_q replicated across all lanes.
//   - mem_be = lanes at byte_off.
//  mem_ack sampled only in RD_WAIT/WR_WAIT; ignored in IDLE.
//  On ack edge:
//   - mem_req<=0, state<=IDLE, done<=1 for exactly one cycle.
//   - RD_WAIT also: mdr_q <= extend(mem_rdata lane at byte_off).
//  Read latency: mdr_q valid and done high in the cycle after the ack cycle.
//  Timeout: timer counts cycles in a WAIT state.
//   - Without ack by TIMEOUT cycles: mem_req<=0, err<=1, done pulse, IDLE.
//   - mdr_q unchanged.
//  Ack in the same cycle timeout expires: ack wins, no error.
//  Inputs mdr_in, mem_rd, mem_wr while busy: ignored (not queued).
//  mdr_q changes only on mdr_in in IDLE, read ack, or reset.
// TESTING
//  1: reset; mdr_in=1, bus_in=32'hDEADBEEF -> next cycle mdr_q=DEADBEEF, done=0.
//  2: read byte, off=2, sign_ext=1, ack 3 cycles later with rdata=32'h0080_0000 -> mdr_q=FFFFFF80, done 1 cycle.
//  3: mdr_q=0000_1234; write half, off=2 -> mem_we=1, mem_be=1100, mem_wdata=1234_1234 until ack.
//  4: read word, off=1 -> err=1, done pulse, mem_req never 1, mdr_q unchanged.
//  5: read with no ack for TIMEOUT=15 cycles -> mem_req drops, err=1, done pulse; next start clears err.
//  6: assert reset in RD_WAIT -> mem_req=0 and mdr_q=0 immediately; late ack ignored; DATA_W=64 dword read fills all bits.

Source files
------------

// File: rtl/mdr_unit.sv
// Memory data register with a built-in memory-port sequencer: bus loads, and handshaked
// byte/half/word/dword reads (lane-extracted, sign/zero-extended) and lane-replicated writes.
module mdr_unit #(
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 15,
  localparam int OFF_W   = $clog2(DATA_W/8)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     bus_in,
  input  logic                  mdr_in,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [OFF_W-1:0]      byte_off,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mdr_q,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NB = DATA_W / 8;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mdr_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [NB-1:0]       be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [7:0]          timer_q, timer_d;
  logic [1:0]          rsize_q, rsize_d;
  logic                rsext_q, rsext_d;
  logic [OFF_W-1:0]    roff_q, roff_d;

  int                  req_nb;
  logic                bad_req;
  logic [NB-1:0]       lane_be;
  logic [DATA_W-1:0]   rep_wdata;

  int                  rd_nb;
  logic                rd_sbit;
  logic [DATA_W-1:0]   rd_lane;
  logic [DATA_W-1:0]   rd_ext;

  // Request decode from the live inputs, used only at the start edge in IDLE.
  always_comb begin
    req_nb  = 1 << size;
    bad_req = ((size == 2'b11) && (DATA_W == 32)) || ((int'(byte_off) % req_nb) != 0);
    lane_be = '0;
    for (int i = 0; i < NB; i++) begin
      lane_be[i] = (i >= int'(byte_off)) && (i < int'(byte_off) + req_nb);
    end
    rep_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      rep_wdata[i*8 +: 8] = mdr_q[(i % req_nb)*8 +: 8];
    end
  end

  // Read extraction uses the request attributes captured at the start edge.
  always_comb begin
    rd_nb   = 1 << rsize_q;
    rd_lane = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < rd_nb) begin
        rd_lane[i*8 +: 8] = mem_rdata[((int'(roff_q) + i) % NB)*8 +: 8];
      end
    end
    rd_sbit = rsext_q & rd_lane[(rd_nb*8 - 1) % DATA_W];
    rd_ext  = rd_lane;
    for (int i = 0; i < NB; i++) begin
      if (i >= rd_nb) begin
        rd_ext[i*8 +: 8] = {8{rd_sbit}};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mdr_d   = mdr_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;
    timer_d = timer_q;
    rsize_d = rsize_q;
    rsext_d = rsext_q;
    roff_d  = roff_q;
    case (state_q)
      IDLE: begin
        if (mem_rd || mem_wr) begin
          err_d = 1'b0;
          if (bad_req) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            req_d   = 1'b1;
            we_d    = !mem_rd;
            be_d    = lane_be;
            wdata_d = mem_rd ? '0 : rep_wdata;
            timer_d = '0;
            rsize_d = size;
            rsext_d = sign_ext;
            roff_d  = byte_off;
            state_d = mem_rd ? RD_WAIT : WR_WAIT;
          end
        end else if (mdr_in) begin
          mdr_d = bus_in;
        end
      end
      RD_WAIT, WR_WAIT: begin
        // Ack takes precedence over a timeout expiring in the same cycle.
        if (mem_ack || (timer_q == TMO_LAST)) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          wdata_d = '0;
          done_d  = 1'b1;
          state_d = IDLE;
          if (mem_ack) begin
            if (state_q == RD_WAIT) mdr_d = rd_ext;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mdr_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= '0;
      rsize_q <= '0;
      rsext_q <= 1'b0;
      roff_q  <= '0;
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      timer_q <= timer_d;
      rsize_q <= rsize_d;
      rsext_q <= rsext_d;
      roff_q  <= roff_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mdr_unit.sv
// Directed bench for mdr_unit: a 32-bit instance for the main scenarios and a
// 64-bit instance for dword and wide-lane cases.
module tb_mdr_unit;

  logic clock;
  logic reset;

  logic [31:0] bus_in, mem_rdata, mem_wdata, mdr_q;
  logic        mdr_in, mem_rd, mem_wr, sign_ext, mem_ack;
  logic [1:0]  size, byte_off;
  logic        mem_req, mem_we, busy, done, err;
  logic [3:0]  mem_be;

  logic [63:0] w_bus_in, w_mem_rdata, w_mem_wdata, w_mdr_q;
  logic        w_mdr_in, w_mem_rd, w_mem_wr, w_sign_ext, w_mem_ack;
  logic [1:0]  w_size;
  logic [2:0]  w_byte_off;
  logic        w_mem_req, w_mem_we, w_busy, w_done, w_err;
  logic [7:0]  w_mem_be;

  int n_chk = 0;
  int n_err = 0;
  int cnt;

  mdr_unit #(.DATA_W(32), .TIMEOUT(15)) u_dut (
    .clock(clock), .reset(reset), .bus_in(bus_in), .mdr_in(mdr_in),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .size(size), .sign_ext(sign_ext),
    .byte_off(byte_off), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mdr_q(mdr_q), .busy(busy), .done(done), .err(err)
  );

  mdr_unit #(.DATA_W(64), .TIMEOUT(15)) u_dut64 (
    .clock(clock), .reset(reset), .bus_in(w_bus_in), .mdr_in(w_mdr_in),
    .mem_rd(w_mem_rd), .mem_wr(w_mem_wr), .size(w_size), .sign_ext(w_sign_ext),
    .byte_off(w_byte_off), .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata),
    .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_be(w_mem_be), .mem_wdata(w_mem_wdata),
    .mdr_q(w_mdr_q), .busy(w_busy), .done(w_done), .err(w_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus_in = '0; mdr_in = 0; mem_rd = 0; mem_wr = 0; size = 0; sign_ext = 0;
    byte_off = 0; mem_ack = 0; mem_rdata = '0;
    w_bus_in = '0; w_mdr_in = 0; w_mem_rd = 0; w_mem_wr = 0; w_size = 0; w_sign_ext = 0;
    w_byte_off = 0; w_mem_ack = 0; w_mem_rdata = '0;
    tick();
    check("rst_mdr", mdr_q, 0);
    check("rst_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset = 1'b0;

    // 1: bus load
    mdr_in = 1; bus_in = 32'hDEADBEEF;
    tick();
    mdr_in = 0;
    check("ld_mdr", mdr_q, 32'hDEADBEEF);
    check("ld_done", done, 0);

    // 2: signed byte read at offset 2, ack three cycles later
    size = 2'b00; byte_off = 2; sign_ext = 1; mem_rd = 1;
    tick();
    mem_rd = 0;
    check("rdb_req", mem_req, 1);
    check("rdb_we", mem_we, 0);
    check("rdb_be", mem_be, 4'b0100);
    check("rdb_busy", busy, 1);
    tick(); tick();
    mem_ack = 1; mem_rdata = 32'h0080_0000;
    tick();
    mem_ack = 0; mem_rdata = '0;
    check("rdb_mdr", mdr_q, 32'hFFFFFF80);
    check("rdb_done", done, 1);
    check("rdb_req_off", mem_req, 0);
    tick();
    check("rdb_done_1cyc", done, 0);

    // 3: half write at offset 2
    mdr_in = 1; bus_in = 32'h0000_1234;
    tick();
    mdr_in = 0;
    size = 2'b01; byte_off = 2; mem_wr = 1;
    tick();
    mem_wr = 0;
    check("wrh_we", mem_we, 1);
    check("wrh_be", mem_be, 4'b1100);
    check("wrh_wdata", mem_wdata, 32'h1234_1234);
    tick();
    check("wrh_req_held", mem_req, 1);
    check("wrh_wdata_held", mem_wdata, 32'h1234_1234);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    check("wrh_done", done, 1);
    check("wrh_req_off", mem_req, 0);
    check("wrh_mdr_keep", mdr_q, 32'h0000_1234);

    // 4: misaligned word read; simultaneous mdr_in loses to mem_rd
    size = 2'b10; byte_off = 1; mem_rd = 1; mdr_in = 1; bus_in = 32'hFFFF_FFFF;
    tick();
    mem_rd = 0; mdr_in = 0;
    check("mis_err", err, 1);
    check("mis_done", done, 1);
    check("mis_req", mem_req, 0);
    check("mis_mdr", mdr_q, 32'h0000_1234);
    tick();
    check("mis_done_off", done, 0);
    check("mis_err_sticky", err, 1);
    check("mis_req2", mem_req, 0);

    // illegal dword on 32-bit
    size = 2'b11; byte_off = 0; mem_wr = 1;
    tick();
    mem_wr = 0;
    check("ill_err", err, 1);
    check("ill_done", done, 1);
    check("ill_busy", busy, 0);

    // ack in IDLE ignored
    mem_ack = 1; mem_rdata = 32'hAAAA_AAAA;
    tick();
    mem_ack = 0;
    check("idle_ack_done", done, 0);
    check("idle_ack_mdr", mdr_q, 32'h0000_1234);

    // 5: timeout
    size = 2'b10; byte_off = 0; mem_rd = 1;
    tick();
    mem_rd = 0;
    check("to_err_clr", err, 0);
    cnt = 0;
    while (mem_req && cnt < 40) begin
      cnt++;
      tick();
    end
    check("to_req_cycles", cnt, 15);
    check("to_err", err, 1);
    check("to_done", done, 1);
    check("to_mdr", mdr_q, 32'h0000_1234);

    // ack on the last allowed cycle wins over the timeout
    size = 2'b00; byte_off = 0; sign_ext = 0; mem_rd = 1;
    tick();
    mem_rd = 0;
    check("edge_err_clr", err, 0);
    repeat (14) tick();
    check("edge_req_still", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h1234_56A5;
    tick();
    mem_ack = 0;
    check("edge_err", err, 0);
    check("edge_done", done, 1);
    check("edge_mdr", mdr_q, 32'h0000_00A5);

    // 6: async reset mid-read, late ack ignored
    size = 2'b10; byte_off = 0; mem_rd = 1;
    tick();
    mem_rd = 0;
    check("rr_req", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    check("rr_req_async", mem_req, 0);
    check("rr_mdr_async", mdr_q, 0);
    check("rr_busy_async", busy, 0);
    #1 reset = 1'b0;
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 0;
    check("rr_late_mdr", mdr_q, 0);
    check("rr_late_done", done, 0);

    // 64-bit: dword read fills all bits
    w_size = 2'b11; w_byte_off = 0; w_mem_rd = 1;
    tick();
    w_mem_rd = 0;
    check("w_dw_be", w_mem_be, 8'hFF);
    check("w_dw_req", w_mem_req, 1);
    w_mem_ack = 1; w_mem_rdata = 64'h8123_4567_89AB_CDEF;
    tick();
    w_mem_ack = 0;
    check("w_dw_mdr", w_mdr_q, 64'h8123_4567_89AB_CDEF);
    check("w_dw_done", w_done, 1);

    // 64-bit signed half at offset 6
    w_size = 2'b01; w_byte_off = 6; w_sign_ext = 1; w_mem_rd = 1;
    tick();
    w_mem_rd = 0;
    check("w_h_be", w_mem_be, 8'hC0);
    w_mem_ack = 1; w_mem_rdata = 64'h8001_0000_0000_0000;
    tick();
    w_mem_ack = 0;
    check("w_h_mdr", w_mdr_q, 64'hFFFF_FFFF_FFFF_8001);

    // 64-bit word write at offset 4
    w_size = 2'b10; w_byte_off = 4; w_mem_wr = 1;
    tick();
    w_mem_wr = 0;
    check("w_w_be", w_mem_be, 8'hF0);
    check("w_w_wdata", w_mem_wdata, 64'hFFFF_8001_FFFF_8001);
    check("w_w_we", w_mem_we, 1);
    w_mem_ack = 1;
    tick();
    w_mem_ack = 0;
    check("w_w_done", w_done, 1);

    // 64-bit misaligned dword
    w_size = 2'b11; w_byte_off = 4; w_mem_rd = 1;
    tick();
    w_mem_rd = 0;
    check("w_mis_err", w_err, 1);
    check("w_mis_req", w_mem_req, 0);
    check("w_mis_mdr", w_mdr_q, 64'hFFFF_FFFF_FFFF_8001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
